// File: rtl/term_ctrl_if.sv
// CPU-side bus of the text-terminal controller: one-cycle access strobe,
// read/write select, address, write data and registered read data.
interface term_ctrl_if;
  logic        ena;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output ena, rw, addr, wdata, input rdata);
  modport slave  (input ena, rw, addr, wdata, output rdata);
endinterface

// File: rtl/term_ctrl.sv
// Text-terminal controller: COLS x ROWS cell buffer, clear/scroll engine,
// ring-buffer top-row pointer, cursor register with blink timer, and a
// scroll-translated display read port for the VGA character generator.
//
// state    | meaning
// S_IDLE   | engine idle, CMD writes accepted
// S_CLEAR  | blanking every cell, then TOP returns to 0
// S_SCROLL | blanking physical row TOP, then TOP advances with wrap
module term_ctrl #(
  parameter int COLS         = 70,
  parameter int ROWS         = 30,
  parameter int ATTR_W       = 8,
  parameter int REG_BASE     = 'h1000,
  parameter int FILL_ATTR    = 'h07,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  term_ctrl_if.slave              bus,
  input  logic [$clog2(ROWS)-1:0] i_disp_row,
  input  logic [$clog2(COLS)-1:0] i_disp_col,
  output logic [8+ATTR_W-1:0]     o_disp_cell,
  output logic [$clog2(ROWS)-1:0] o_cursor_row,
  output logic [$clog2(COLS)-1:0] o_cursor_col,
  output logic                    o_cursor_on,
  output logic                    o_busy
);
  localparam int CW      = 8 + ATTR_W;
  localparam int ROW_W   = $clog2(ROWS);
  localparam int COL_W   = $clog2(COLS);
  localparam int CELLS   = COLS * ROWS;
  localparam int IDX_W   = $clog2(CELLS);
  localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
  localparam logic MEM_READ = 1'b1;
  localparam logic [CW-1:0] BLANK = {ATTR_W'(FILL_ATTR), 8'h20};

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCROLL} state_t;
  state_t r_state, w_next;

  logic [CW-1:0]      r_mem [CELLS];
  logic [IDX_W-1:0]   r_cnt;
  logic [ROW_W-1:0]   r_top;
  logic [IDX_W-1:0]   r_top_base;   // r_top * COLS, tracked by addition
  logic [7:0]         r_cur_col;
  logic [7:0]         r_cur_row;
  logic               r_cur_en;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_phase;
  logic [31:0]        r_rdata;
  logic [CW-1:0]      r_disp_cell;

  logic               w_rd, w_wr, w_is_cell, w_is_cmd, w_is_top, w_is_cur, w_cur_ok;
  logic [IDX_W-1:0]   w_cell_idx;
  logic               w_busy, w_eng_we, w_last;
  logic [IDX_W-1:0]   w_eng_idx;
  logic [31:0]        w_rd_val;
  logic [ROW_W:0]     w_row_sum;
  logic [ROW_W-1:0]   w_phys_row;
  logic [IDX_W-1:0]   w_disp_idx;
  logic               w_disp_ok;

  assign w_rd       = bus.ena & (bus.rw == MEM_READ);
  assign w_wr       = bus.ena & (bus.rw != MEM_READ);
  assign w_is_cell  = bus.addr < 32'(CELLS);
  assign w_cell_idx = bus.addr[IDX_W-1:0];
  assign w_is_cmd   = bus.addr == 32'(REG_BASE);
  assign w_is_top   = bus.addr == 32'(REG_BASE + 1);
  assign w_is_cur   = bus.addr == 32'(REG_BASE + 2);
  assign w_cur_ok   = (bus.wdata[7:0] < 8'(COLS)) && (bus.wdata[15:8] < 8'(ROWS));

  // Display translation: logical row + TOP folded back into range without a divider.
  assign w_row_sum  = {1'b0, i_disp_row} + {1'b0, r_top};
  assign w_phys_row = (w_row_sum >= (ROW_W+1)'(ROWS)) ? ROW_W'(w_row_sum - (ROW_W+1)'(ROWS))
                                                      : ROW_W'(w_row_sum);
  assign w_disp_idx = IDX_W'(w_phys_row) * IDX_W'(COLS) + IDX_W'(i_disp_col);
  assign w_disp_ok  = ({1'b0, i_disp_row} < (ROW_W+1)'(ROWS)) &&
                      ({1'b0, i_disp_col} < (COL_W+1)'(COLS));

  // Engine state register; reset aborts any clear/scroll in progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Engine next-state: commands only start from idle, engine runs to its last write.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_wr && w_is_cmd && bus.wdata == 32'd1)      w_next = S_CLEAR;
        else if (w_wr && w_is_cmd && bus.wdata == 32'd2) w_next = S_SCROLL;
      end
      S_CLEAR, S_SCROLL: if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Engine outputs: busy flag, blank-cell write enable and target index.
  always_comb begin
    w_busy    = 1'b0;
    w_eng_we  = 1'b0;
    w_eng_idx = r_cnt;
    w_last    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_busy   = 1'b1;
        w_eng_we = 1'b1;
        w_last   = (r_cnt == IDX_W'(CELLS - 1));
      end
      S_SCROLL: begin
        w_busy    = 1'b1;
        w_eng_we  = 1'b1;
        w_eng_idx = r_top_base + r_cnt;
        w_last    = (r_cnt == IDX_W'(COLS - 1));
      end
      default: ;
    endcase
  end

  // Engine progress counter and TOP pointer update on the final engine write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_top      <= '0;
      r_top_base <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        if (r_state == S_CLEAR || r_top == ROW_W'(ROWS - 1)) begin
          r_top      <= '0;
          r_top_base <= '0;
        end else begin
          r_top      <= r_top + 1'b1;
          r_top_base <= r_top_base + IDX_W'(COLS);
        end
      end
    end
  end

  // Port A write: engine owns the port while busy, so CPU cell writes are dropped.
  always_ff @(posedge i_clk) begin
    if (w_eng_we)               r_mem[w_eng_idx]  <= BLANK;
    else if (w_wr && w_is_cell) r_mem[w_cell_idx] <= bus.wdata[CW-1:0];
  end

  // CPU read data mux; cells read as zero while the engine is running.
  always_comb begin
    w_rd_val = '0;
    if (w_is_cell)     w_rd_val = w_busy ? 32'd0 : 32'(r_mem[w_cell_idx]);
    else if (w_is_cmd) w_rd_val = {31'b0, w_busy};
    else if (w_is_top) w_rd_val = 32'(r_top);
    else if (w_is_cur) w_rd_val = {15'b0, r_cur_en, r_cur_row, r_cur_col};
  end

  // Registered CPU read data (held between reads) and display read port B.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata     <= '0;
      r_disp_cell <= '0;
    end else begin
      if (w_rd) r_rdata <= w_rd_val;
      r_disp_cell <= w_disp_ok ? r_mem[w_disp_idx] : '0;
    end
  end

  // Cursor register; a write with out-of-range row or column is discarded whole.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cur_col <= '0;
      r_cur_row <= '0;
      r_cur_en  <= 1'b0;
    end else if (w_wr && w_is_cur && w_cur_ok) begin
      r_cur_col <= bus.wdata[7:0];
      r_cur_row <= bus.wdata[15:8];
      r_cur_en  <= bus.wdata[16];
    end
  end

  // Blink timer: phase flips once every BLINK_CYCLES clocks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign bus.rdata    = r_rdata;
  assign o_disp_cell  = r_disp_cell;
  assign o_cursor_row = r_cur_row[ROW_W-1:0];
  assign o_cursor_col = r_cur_col[COL_W-1:0];
  assign o_cursor_on  = r_phase & r_cur_en;
  assign o_busy       = w_busy;
endmodule

// File: tb/tb_term_ctrl.sv
// Directed bench for term_ctrl with scoreboards for CPU reads and display reads.
module tb_term_ctrl;
  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int BLINK = 4;
  localparam logic [31:0] A_CMD = 32'h1000;
  localparam logic [31:0] A_TOP = 32'h1001;
  localparam logic [31:0] A_CUR = 32'h1002;
  localparam logic [31:0] BLANK = 32'h0720;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  disp_row = '0;
  logic [6:0]  disp_col = '0;
  logic [15:0] disp_cell;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;
  logic        cur_on, busy;
  logic        rd_pend = 1'b0, dp_req = 1'b0, dp_pend = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] q_rd[$];
  string       q_rdn[$];
  logic [15:0] q_dp[$];
  string       q_dpn[$];

  term_ctrl_if bus();

  term_ctrl #(.COLS(COLS), .ROWS(ROWS), .ATTR_W(8), .REG_BASE('h1000),
              .FILL_ATTR('h07), .BLINK_CYCLES(BLINK)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus),
    .i_disp_row(disp_row), .i_disp_col(disp_col), .o_disp_cell(disp_cell),
    .o_cursor_row(cur_row), .o_cursor_col(cur_col), .o_cursor_on(cur_on),
    .o_busy(busy));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= bus.ena & bus.rw;
    dp_pend <= dp_req;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic monitor_loop();
    logic [31:0] e32;
    logic [15:0] e16;
    string nm;
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        n_vec++;
        if (q_rd.size() == 0) begin
          n_err++;
          $display("FAIL rdata_unexpected got=%0h exp=none", bus.rdata);
        end else begin
          e32 = q_rd.pop_front();
          nm  = q_rdn.pop_front();
          if (bus.rdata !== e32) begin
            n_err++;
            $display("FAIL %s rdata got=%0h exp=%0h", nm, bus.rdata, e32);
          end
        end
      end
      if (dp_pend) begin
        n_vec++;
        if (q_dp.size() == 0) begin
          n_err++;
          $display("FAIL disp_unexpected got=%0h exp=none", disp_cell);
        end else begin
          e16 = q_dp.pop_front();
          nm  = q_dpn.pop_front();
          if (disp_cell !== e16) begin
            n_err++;
            $display("FAIL %s disp_cell got=%0h exp=%0h", nm, disp_cell, e16);
          end
        end
      end
    end
  endtask

  task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
    bus.ena = 1'b1; bus.rw = 1'b0; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.ena = 1'b0;
  endtask

  task automatic cpu_rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    q_rd.push_back(exp);
    q_rdn.push_back(nm);
    bus.ena = 1'b1; bus.rw = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.ena = 1'b0;
  endtask

  task automatic disp_rd(input int r, input int c, input logic [15:0] exp, input string nm);
    q_dp.push_back(exp);
    q_dpn.push_back(nm);
    disp_row = 5'(r); disp_col = 7'(c); dp_req = 1'b1;
    @(negedge clk);
    dp_req = 1'b0;
  endtask

  task automatic wait_idle(input int cstart, input int exp_len, input string nm);
    int n = 0;
    while (busy === 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (busy === 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout busy got=1 exp=0", nm);
    end else begin
      chk({nm, "_busy_len"}, 32'(cyc - cstart), 32'(exp_len));
    end
  endtask

  task automatic do_scroll(input string nm);
    int c0;
    cpu_wr(A_CMD, 32'd2);
    c0 = cyc;
    chk({nm, "_busy_start"}, 32'(busy), 32'd1);
    wait_idle(c0, COLS, nm);
  endtask

  initial begin
    int c0;
    int first;
    logic v[24];
    bus.ena = 1'b0; bus.rw = 1'b1; bus.addr = '0; bus.wdata = '0;
    fork monitor_loop(); join_none

    repeat (3) @(negedge clk);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_rdata",     bus.rdata,      32'd0);
    chk("rst_disp_cell", 32'(disp_cell), 32'd0);
    chk("rst_cursor_on", 32'(cur_on),    32'd0);
    chk("rst_cur_row",   32'(cur_row),   32'd0);
    chk("rst_cur_col",   32'(cur_col),   32'd0);
    rst = 1'b0;

    cpu_wr(32'd5, 32'h0741);
    cpu_rd(32'd5, 32'h0741, "cell5");
    cpu_wr(32'd6, 32'hFFFF_0742);
    cpu_rd(32'd6, 32'h0742, "cell6_trunc");
    cpu_rd(A_TOP, 32'd0, "top_rst");
    cpu_rd(A_CMD, 32'd0, "status_idle");
    cpu_rd(A_CUR, 32'd0, "cursor_rst");
    cpu_rd(32'h1007, 32'd0, "unmapped");
    cpu_wr(32'd70, 32'h1234);
    cpu_wr(32'd2099, 32'h4321);
    cpu_wr(A_CMD, 32'd3);
    chk("cmd3_ignored", 32'(busy), 32'd0);

    do_scroll("scroll1");
    cpu_rd(A_TOP, 32'd1, "top_after_scroll");
    cpu_rd(32'd0, BLANK, "scroll_cell0");
    cpu_rd(32'd5, BLANK, "scroll_cell5");
    cpu_rd(32'd69, BLANK, "scroll_cell69");
    cpu_rd(32'd70, 32'h1234, "row1_intact");
    disp_rd(29, 0, 16'h0720, "disp_r29_c0");
    disp_rd(0, 0, 16'h1234, "disp_r0_phys1");
    disp_rd(28, 69, 16'h4321, "disp_r28_c69");

    for (int k = 2; k <= 30; k++) begin
      do_scroll("scroll_seq");
      cpu_rd(A_TOP, 32'(k % 30), $sformatf("top_seq%0d", k));
    end
    cpu_wr(32'd3, 32'hABCD);
    disp_rd(0, 3, 16'hABCD, "disp_wrap_r0");

    q_dp.push_back(16'hABCD); q_dpn.push_back("disp_same_cycle_old");
    disp_row = 5'd0; disp_col = 7'd3; dp_req = 1'b1;
    bus.ena = 1'b1; bus.rw = 1'b0; bus.addr = 32'd3; bus.wdata = 32'h1111;
    @(negedge clk);
    dp_req = 1'b0; bus.ena = 1'b0;
    disp_rd(0, 3, 16'h1111, "disp_after_write");

    for (int k = 1; k <= 7; k++) do_scroll("scroll_to7");
    cpu_rd(A_TOP, 32'd7, "top7");

    cpu_wr(A_CMD, 32'd1);
    c0 = cyc;
    chk("clear_busy_start", 32'(busy), 32'd1);
    repeat (100) @(negedge clk);
    cpu_wr(32'd10, 32'h9999);
    cpu_rd(32'd10, 32'd0, "cell_rd_busy");
    cpu_wr(A_CMD, 32'd2);
    cpu_rd(A_CMD, 32'd1, "status_busy");
    cpu_rd(A_TOP, 32'd7, "top_during_clear");
    wait_idle(c0, CELLS, "clear");
    cpu_rd(A_TOP, 32'd0, "top_after_clear");
    for (int i = 0; i < CELLS; i++) cpu_rd(32'(i), BLANK, $sformatf("clear_cell%0d", i));
    disp_rd(29, 69, 16'h0720, "disp_after_clear");

    cpu_wr(A_CUR, 32'h1_0A05);
    chk("cur_row", 32'(cur_row), 32'd10);
    chk("cur_col", 32'(cur_col), 32'd5);
    cpu_rd(A_CUR, 32'h1_0A05, "cursor_rb");
    for (int i = 0; i < 24; i++) begin
      v[i] = cur_on;
      @(negedge clk);
    end
    first = 0;
    for (int i = 4; i >= 1; i--) if (v[i] != v[i-1]) first = i;
    chk("blink_toggle_seen", 32'(first != 0), 32'd1);
    if (first != 0)
      for (int j = first; j < 24; j++)
        chk($sformatf("blink_s%0d", j), 32'(v[j]), 32'(v[first] ^ (((j - first) / BLINK) % 2 == 1)));
    cpu_wr(A_CUR, 32'h1_0A46);
    chk("cur_col70_row", 32'(cur_row), 32'd10);
    chk("cur_col70_col", 32'(cur_col), 32'd5);
    cpu_wr(A_CUR, 32'h1_1E05);
    chk("cur_row30_row", 32'(cur_row), 32'd10);
    cpu_wr(A_CUR, 32'h1_1D45);
    chk("cur_edge_row", 32'(cur_row), 32'd29);
    chk("cur_edge_col", 32'(cur_col), 32'd69);
    cpu_wr(A_CUR, 32'h0_0A05);
    cpu_rd(A_CUR, 32'h0_0A05, "cursor_dis_rb");
    first = 0;
    for (int i = 0; i < 8; i++) begin
      if (cur_on !== 1'b0) first = 1;
      @(negedge clk);
    end
    chk("cursor_off_when_disabled", 32'(first), 32'd0);

    do_scroll("pre_rst");
    cpu_wr(A_CMD, 32'd2);
    repeat (19) @(negedge clk);
    chk("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("busy_after_rst", 32'(busy), 32'd0);
    chk("cur_row_after_rst", 32'(cur_row), 32'd0);
    cpu_rd(A_TOP, 32'd0, "top_after_rst");
    do_scroll("after_rst");
    cpu_rd(A_TOP, 32'd1, "top_after_rst_scroll");

    repeat (3) @(negedge clk);
    chk("rd_queue_drained", 32'(q_rd.size()), 32'd0);
    chk("disp_queue_drained", 32'(q_dp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
